// File: rtl/uart_frame_rx_if.sv
// Bundle between the UART frame receiver and its neighbours.
// Latency: none (wires only).
// Backpressure: none; the consumer must accept every valid strobe.
// Ports:
//   rx        serial line into the receiver, idle high
//   data      last complete 96-bit payload
//   valid     one-cycle strobe when data updates
//   frame_err one-cycle strobe on a framing or trailer error
//   busy      receiver is inside a byte or a partial frame
interface uart_frame_rx_if;
    logic        rx;
    logic [95:0] data;
    logic        valid;
    logic        frame_err;
    logic        busy;

    // master drives the line and consumes the frame; slave is the receiver
    modport master (output rx, input data, input valid, input frame_err, input busy);
    modport slave  (input rx, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_frame_rx.sv
// Deserialises 8N1 bytes and rebuilds a 13-byte frame (12 payload bytes, MSB first, then TRAILER).
// Latency: valid/frame_err one cycle after the deciding stop-bit sample (~2 + BAUD_DIV/2 after that bit's edge).
// Backpressure: none; a serial line cannot be stalled, so the consumer must take each valid strobe.
// Ports:
//   clk_50  system clock
//   rst_n   asynchronous active-low reset
//   fr      uart_frame_rx_if slave: rx in; data, valid, frame_err, busy out
module uart_frame_rx #(
    parameter int         BAUD_DIV = 434,
    parameter logic [7:0] TRAILER  = 8'hF0,
    parameter int         IDLE_TO  = 20
) (
    input  logic          clk_50,
    input  logic          rst_n,
    uart_frame_rx_if.slave fr
);

    localparam int TW     = $clog2(BAUD_DIV);
    localparam int TO_CYC = IDLE_TO * BAUD_DIV;
    localparam int IW     = $clog2(TO_CYC + 1);

    localparam logic [TW-1:0] HALF_M1 = TW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] TO_LAST = IW'(TO_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // synchroniser plus one more stage for falling-edge detect
    logic rx_meta;
    logic rxs;
    logic rxs_d;

    logic [1:0]    state;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    sr;

    logic [95:0]   win;
    logic [3:0]    cnt;
    logic [IW-1:0] idle_cnt;
    logic [95:0]   data_q;
    logic          valid_q;
    logic          err_q;

    logic tmr_exp;
    logic start_det;
    logic byte_ok;
    logic stop_err;
    logic idle_run;
    logic timeout;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= fr.rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign tmr_exp   = (tmr == '0);
    assign start_det = (state == S_IDLE) && rxs_d && !rxs;
    // the byte in sr is final once the engine reaches STOP
    assign byte_ok   = (state == S_STOP) && tmr_exp && rxs;
    assign stop_err  = (state == S_STOP) && tmr_exp && !rxs;

    // ---------------- bit engine ----------------
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            sr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_det) begin
                        state <= S_START;
                        tmr   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (tmr_exp) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            tmr     <= FULL_M1;
                            bit_idx <= '0;
                        end else begin
                            // line went back high before mid-start: a glitch
                            state <= S_IDLE;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                S_DATA: begin
                    if (tmr_exp) begin
                        sr  <= {rxs, sr[7:1]};
                        tmr <= FULL_M1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: begin
                    // leave mid-stop bit so the next start edge is never missed
                    if (tmr_exp) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- idle timeout ----------------
    // only runs between bytes of a partial frame; any start edge restarts it
    assign idle_run = (state == S_IDLE) && (cnt != 4'd0) && !start_det;
    assign timeout  = idle_run && (idle_cnt == TO_LAST);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (idle_run && !timeout) begin
            idle_cnt <= idle_cnt + IW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end

    // ---------------- frame assembler ----------------
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            win     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (stop_err) begin
                err_q <= 1'b1;
                cnt   <= '0;
            end else if (byte_ok) begin
                if (cnt != 4'd12) begin
                    win <= {win[87:0], sr};
                    cnt <= cnt + 4'd1;
                end else if (sr == TRAILER) begin
                    data_q  <= win;
                    valid_q <= 1'b1;
                    cnt     <= '0;
                end else begin
                    // slide the window by one byte and keep hunting for the trailer
                    err_q <= 1'b1;
                    win   <= {win[87:0], sr};
                end
            end else if (timeout) begin
                cnt <= '0;
            end
        end
    end

    assign fr.data      = data_q;
    assign fr.valid     = valid_q;
    assign fr.frame_err = err_q;
    assign fr.busy      = (state != S_IDLE) || (cnt != 4'd0);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: drives 8N1 serial frames and scores valid/frame_err pulses.
// Latency: pulses expected mid stop bit of the deciding byte.
// Backpressure: none; every DUT pulse is popped from the expectation queue.
module tb_uart_frame_rx;

    localparam int         BAUD    = 32;
    localparam int         IDLE_TO = 20;
    localparam logic [7:0] TRAILER = 8'hF0;

    typedef struct {
        bit          is_err;
        logic [95:0] dat;
    } exp_t;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;

    uart_frame_rx_if u_if ();

    uart_frame_rx #(
        .BAUD_DIV (BAUD),
        .TRAILER  (TRAILER),
        .IDLE_TO  (IDLE_TO)
    ) dut (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .fr     (u_if)
    );

    always #10 clk_50 = ~clk_50;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [95:0] last_good = '0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard: every pulse must match the head of the expectation queue
    always @(negedge clk_50) begin : mon
        exp_t e;
        if (rst_n && (u_if.valid || u_if.frame_err)) begin
            check_eq("pulse_excl", 96'(u_if.valid & u_if.frame_err), 96'(0));
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 96'({u_if.valid, u_if.frame_err}), 96'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse_kind", 96'(u_if.frame_err), 96'(e.is_err));
                if (e.is_err) begin
                    check_eq("data_hold", u_if.data, last_good);
                end else begin
                    check_eq("data", u_if.data, e.dat);
                    check_eq("busy_at_valid", 96'(u_if.busy), 96'(0));
                    last_good = e.dat;
                end
            end
        end
    end

    task automatic bit_time(input logic v);
        u_if.rx = v;
        repeat (BAUD) @(negedge clk_50);
    endtask

    task automatic idle_bits(input int n);
        u_if.rx = 1'b1;
        repeat (n * BAUD) @(negedge clk_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
    endtask

    task automatic send_payload(input logic [95:0] p);
        for (int i = 0; i < 12; i++) send_byte(p[95 - 8*i -: 8], 1'b1);
    endtask

    task automatic send_frame(input logic [95:0] p);
        exp_q.push_back('{is_err: 1'b0, dat: p});
        send_payload(p);
        send_byte(TRAILER, 1'b1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        u_if.rx = 1'b1;
        repeat (5) @(negedge clk_50);
        check_eq("rst_data", u_if.data, 96'(0));
        check_eq("rst_valid", 96'(u_if.valid), 96'(0));
        check_eq("rst_frame_err", 96'(u_if.frame_err), 96'(0));
        check_eq("rst_busy", 96'(u_if.busy), 96'(0));
        exp_q.delete();
        last_good = '0;
        rst_n = 1'b1;
    endtask

    localparam logic [95:0] P_NOM = 96'h0102030405060708090A0B0C;
    localparam logic [95:0] P_RST = 96'h1112131415161718191A1B1C;
    localparam logic [95:0] P_TRL = 96'hF0112233445566F0778899AA;

    initial begin
        u_if.rx = 1'b1;
        @(negedge clk_50);

        // reset and quiet line
        do_reset();
        repeat (1000) @(negedge clk_50);

        // short glitch on idle line: no byte, engine back to idle
        u_if.rx = 1'b0;
        repeat (BAUD / 4) @(negedge clk_50);
        idle_bits(20);
        check_eq("glitch_busy", 96'(u_if.busy), 96'(0));

        // nominal frame
        send_frame(P_NOM);
        idle_bits(2);

        // reset in the middle of byte 7
        for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 1'b1);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        do_reset();
        idle_bits(2);
        send_frame(P_RST);
        idle_bits(2);

        // leading junk byte: trailer mismatch on 0x0C, then resync
        exp_q.push_back('{is_err: 1'b1, dat: 96'h0});
        exp_q.push_back('{is_err: 1'b0, dat: P_NOM});
        send_byte(8'hAA, 1'b1);
        send_payload(P_NOM);
        send_byte(TRAILER, 1'b1);
        idle_bits(2);

        // stop-bit error on byte 5, then a clean frame with 0xF0 payload bytes
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        exp_q.push_back('{is_err: 1'b1, dat: 96'h0});
        send_byte(8'h05, 1'b0);
        idle_bits(2);
        check_eq("stoperr_busy", 96'(u_if.busy), 96'(0));
        send_frame(P_TRL);
        idle_bits(2);

        // partial frame then idle timeout
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b1);
        idle_bits(10);
        check_eq("partial_busy", 96'(u_if.busy), 96'(1));
        idle_bits(11);
        check_eq("timeout_busy", 96'(u_if.busy), 96'(0));
        send_frame(P_NOM);
        idle_bits(4);

        check_eq("queue_empty", 96'(exp_q.size()), 96'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Receive-side counterpart of the 96-bit UART frame transmitter: deserialises 8N1 bytes from `rx` and reassembles the 13-byte frame (12 payload bytes, MSB byte first, then trailer 0xF0). Sits on the receiving FPGA/board, directly downstream of the transmit link. Presents the reconstructed 96-bit word with a one-cycle strobe to the consuming logic.

## Interface
- BAUD_DIV, 434, clk_50 cycles per bit (115200 baud at 50 MHz); must be ≥ 16.
- TRAILER, 8'hF0, frame terminator byte.
- IDLE_TO, 20, mid-frame idle limit in bit periods before the partial frame is dropped.
- clk_50  in  1  50 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, idle high, asynchronous to clk_50.
- data  out  96  last complete payload; first received byte in data[95:88], last payload byte in data[7:0].
- valid  out  1  one-cycle pulse when data is updated.
- frame_err  out  1  one-cycle pulse on stop-bit error or trailer mismatch.
- busy  out  1  high from start-bit detect until a frame completes, errors, or times out.

## Operation
- Input path: rx through a 2-flop synchroniser; reset value of both flops 1. All logic uses the synchronised signal `rxs`.
- Bit engine states: IDLE, START, DATA, STOP.
  - IDLE: `rxs` falling edge → START, bit timer loaded with BAUD_DIV/2 − 1.
  - START: at timer expiry sample `rxs`; 0 → DATA (timer = BAUD_DIV − 1, bit index 0); 1 → IDLE (glitch, no error).
  - DATA: sample at each expiry, LSB first, 8 samples, then → STOP.
  - STOP: sample at expiry; 1 → byte accepted; 0 → stop error. Either way return to IDLE immediately after the sample (mid-stop bit) so back-to-back bytes are not missed.
- Frame assembler: 96-bit shift window `win`, byte counter `cnt` 0..12, saturating at 12.
  - Accepted byte, cnt < 12: win = {win[87:0], byte}; cnt + 1.
  - Accepted byte, cnt == 12, byte == TRAILER: data ← win, valid pulse, cnt ← 0.
  - Accepted byte, cnt == 12, byte ≠ TRAILER: frame_err pulse, win shifted by byte (sliding resync), cnt stays 12.
  - Stop error: byte discarded, frame_err pulse, cnt ← 0.
  - A payload byte equal to TRAILER while cnt < 12 is ordinary payload.
- Idle timeout: while cnt ≠ 0 and engine in IDLE, count cycles; at IDLE_TO × BAUD_DIV cycles, cnt ← 0 with no error pulse. Counter clears on every start-bit detect.
- busy = (engine ≠ IDLE) | (cnt ≠ 0).

## Timing
- Reset values: data 0, valid 0, frame_err 0, busy 0, engine IDLE, cnt 0, win 0, timers 0.
- Reset asserted mid-byte or mid-frame: everything returns to reset values at once; the partial frame is lost and no pulse is emitted.
- Sample point: `rxs` edge + BAUD_DIV/2 within each bit; including the 2-cycle synchroniser, the first sample is at rx edge + 2 + BAUD_DIV/2 cycles (±1).
- valid and frame_err are registered and asserted the cycle after the deciding stop-bit sample, for exactly one cycle. They are never asserted together.
- data changes only in the cycle valid rises and holds until the next valid frame.
- Throughput: accepts continuous back-to-back bytes with a stop bit of exactly 1 bit, and baud mismatch up to ±2 %.

## Test plan
- Reset: rst_n low for 5 cycles with rx = 1 → all outputs 0 and busy 0. Release; 1000 idle cycles → no pulses.
- Nominal frame: bytes 0x01..0x0C then 0xF0 back-to-back at BAUD_DIV = 434 → a single valid pulse, data = 96'h0102030405060708090A0B0C, frame_err 0, busy drops with valid.
- Trailer mismatch/resync: 0xAA, then 0x01..0x0C, then 0xF0 (14 bytes) → one frame_err pulse on the 13th byte (0x0C), then valid with data = 96'h0102030405060708090A0B0C.
- Stop error: frame with byte 5 sent with stop bit 0, then a clean full frame → frame_err once, cnt reset, the following clean frame produces valid with the correct data.
- Glitch and timeout: 100-cycle low pulse on idle rx → no byte and no error. Send 5 bytes, then idle for 21 × 434 cycles → busy falls, no pulse. A following full frame → valid.
- Reset mid-frame: assert rst_n during byte 7 → data stays 0. After release, a full frame → correct valid.
